output_divn: RTL and testbench

Parametrised programmable output divider, the successor to the fixed divide-by-2 output stage. It divides the clock by a runtime-selectable integer N in [2, 2^WIDTH−1] and produces a registered, glitch-free output with duty cycle floor(N/2)/N (exactly 50 % for even N). Ratio changes are handshaked and take effect only on a period boundary. Start and stop are graceful: the output never produces a truncated high or low phase. It sits at the end of the fractional-N divider chain, driving the PLL output / feedback path.

---
 rtl/output_divn.sv | 120 ++++++++++++
 tb/tb_output_divn.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/output_divn.sv
// Programmable integer clock divider (N in [2, 2^WIDTH-1]) with registered glitch-free
// output, handshaked ratio changes applied on period boundaries, and graceful start/stop.
module output_divn #(
    parameter int WIDTH     = 8,
    parameter int DEF_RATIO = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] div_ratio,
    input  logic             ratio_load,
    output logic             ratio_ack,
    output logic [WIDTH-1:0] active_ratio,
    output logic             out,
    output logic             out_pulse,
    output logic             busy
);

    // state | meaning
    // IDLE  | output parked low, counter held at 0
    // RUN   | dividing, en still requested
    // STOP  | en dropped; finishing the current period before parking
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] cnt, cnt_nxt, cnt_inc;
    logic [WIDTH-1:0] pending, pending_nxt;
    logic [WIDTH-1:0] ratio_nxt, ld_val;
    logic             pend, pend_nxt;
    logic             ack_nxt, out_nxt, pulse_nxt, busy_nxt;
    logic             wrap;

    always_comb begin
        ld_val      = (div_ratio < WIDTH'(2)) ? WIDTH'(2) : div_ratio;
        wrap        = (cnt == active_ratio - WIDTH'(1));
        cnt_inc     = wrap ? '0 : cnt + WIDTH'(1);
        state_nxt   = state;
        cnt_nxt     = cnt;
        ratio_nxt   = active_ratio;
        pend_nxt    = pend;
        pending_nxt = pending;
        ack_nxt     = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                // A load caught on the STOP->IDLE edge lands in pending; apply it here.
                if (ratio_load) begin
                    ratio_nxt = ld_val;
                    ack_nxt   = 1'b1;
                    pend_nxt  = 1'b0;
                end else if (pend) begin
                    ratio_nxt = pending;
                    ack_nxt   = 1'b1;
                    pend_nxt  = 1'b0;
                end
                if (en) begin
                    state_nxt = RUN;
                end
            end
            RUN, STOP: begin
                cnt_nxt = cnt_inc;
                if (wrap && pend) begin
                    ratio_nxt = pending;
                    pend_nxt  = 1'b0;
                    ack_nxt   = 1'b1;
                end
                if (ratio_load) begin
                    pending_nxt = ld_val;
                    pend_nxt    = 1'b1;
                end
                if (state == RUN) begin
                    if (!en) begin
                        state_nxt = STOP;
                    end
                end else if (en) begin
                    state_nxt = RUN;
                end else if (wrap) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
        busy_nxt  = (state_nxt != IDLE);
        out_nxt   = busy_nxt && (cnt_nxt < (ratio_nxt >> 1));
        pulse_nxt = busy_nxt && (cnt_nxt == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            pend         <= 1'b0;
            pending      <= '0;
            active_ratio <= WIDTH'(DEF_RATIO);
            out          <= 1'b0;
            out_pulse    <= 1'b0;
            ratio_ack    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            pend         <= pend_nxt;
            pending      <= pending_nxt;
            active_ratio <= ratio_nxt;
            out          <= out_nxt;
            out_pulse    <= pulse_nxt;
            ratio_ack    <= ack_nxt;
            busy         <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_output_divn.sv
// Directed self-checking bench for output_divn: vector table for start/stop/load basics,
// hand sequences for ratio handoff, graceful stop/restart and mid-period reset.
module tb_output_divn;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [7:0] div_ratio = 8'd0;
    logic       ratio_load = 1'b0;
    logic       ratio_ack;
    logic [7:0] active_ratio;
    logic       out;
    logic       out_pulse;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    output_divn #(.WIDTH(8), .DEF_RATIO(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .div_ratio    (div_ratio),
        .ratio_load   (ratio_load),
        .ratio_ack    (ratio_ack),
        .active_ratio (active_ratio),
        .out          (out),
        .out_pulse    (out_pulse),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int r, e, l, rat;
        int o, p, b, a, act;
    } vec_t;

    vec_t vt[$];

    task automatic add(input int r, e, l, rat, o, p, b, a, act);
        vec_t v;
        v.r = r; v.e = e; v.l = l; v.rat = rat;
        v.o = o; v.p = p; v.b = b; v.a = a; v.act = act;
        vt.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] got, input int exp);
        n_checks++;
        if (got !== 32'(exp)) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0d expected %0d", nm, idx, got, exp);
        end
    endtask

    task automatic cyc(input int r, e, l, rat);
        rst        = r[0];
        en         = e[0];
        ratio_load = l[0];
        div_ratio  = rat[7:0];
        @(posedge clk);
        #1;
    endtask

    task automatic expect_all(input string nm, input int idx, input int o, p, b, a, act);
        chk({nm, ".out"},       idx, 32'(out),          o);
        chk({nm, ".out_pulse"}, idx, 32'(out_pulse),    p);
        chk({nm, ".busy"},      idx, 32'(busy),         b);
        chk({nm, ".ratio_ack"}, idx, 32'(ratio_ack),    a);
        chk({nm, ".active"},    idx, 32'(active_ratio), act);
    endtask

    task automatic step(input string nm, input int idx, input int r, e, l, rat,
                        input int o, p, b, a, act);
        cyc(r, e, l, rat);
        expect_all(nm, idx, o, p, b, a, act);
    endtask

    initial begin
        // reset, default N=2 run, stop from cnt=1
        add(1,0,0,0, 0,0,0,0,2);
        add(0,0,0,0, 0,0,0,0,2);
        add(0,1,0,0, 1,1,1,0,2);
        add(0,1,0,0, 0,0,1,0,2);
        add(0,1,0,0, 1,1,1,0,2);
        add(0,1,0,0, 0,0,1,0,2);
        add(0,0,0,0, 1,1,1,0,2);
        add(0,0,0,0, 0,0,1,0,2);
        add(0,0,0,0, 0,0,0,0,2);
        // load 5 in IDLE, run 11000
        add(0,0,1,5, 0,0,0,1,5);
        add(0,0,0,0, 0,0,0,0,5);
        add(0,1,0,0, 1,1,1,0,5);
        add(0,1,0,0, 1,0,1,0,5);
        add(0,1,0,0, 0,0,1,0,5);
        add(0,1,0,0, 0,0,1,0,5);
        add(0,1,0,0, 0,0,1,0,5);
        add(0,1,0,0, 1,1,1,0,5);
        add(0,1,0,0, 1,0,1,0,5);
        add(0,0,0,0, 0,0,1,0,5);
        add(0,0,0,0, 0,0,1,0,5);
        add(0,0,0,0, 0,0,1,0,5);
        add(0,0,0,0, 0,0,0,0,5);
        // clamp of 0 and 1, equal-ratio reload while running
        add(0,0,1,0, 0,0,0,1,2);
        add(0,0,1,7, 0,0,0,1,7);
        add(0,0,1,1, 0,0,0,1,2);
        add(0,1,0,0, 1,1,1,0,2);
        add(0,1,0,0, 0,0,1,0,2);
        add(0,1,0,0, 1,1,1,0,2);
        add(0,1,1,0, 0,0,1,0,2);
        add(0,1,0,0, 1,1,1,1,2);
        add(0,1,0,0, 0,0,1,0,2);
        add(0,0,0,0, 1,1,1,0,2);
        add(0,0,0,0, 0,0,1,0,2);
        add(0,0,0,0, 0,0,0,0,2);

        @(posedge clk);
        #1;
        foreach (vt[i]) begin
            step("vec", i, vt[i].r, vt[i].e, vt[i].l, vt[i].rat,
                 vt[i].o, vt[i].p, vt[i].b, vt[i].a, vt[i].act);
        end

        // N=4 running, load 7 then 3 mid-period: one ack at the wrap, next period 100
        step("handoff", 0,  0,0,1,4, 0,0,0,1,4);
        step("handoff", 1,  0,1,0,0, 1,1,1,0,4);
        step("handoff", 2,  0,1,1,7, 1,0,1,0,4);
        step("handoff", 3,  0,1,1,3, 0,0,1,0,4);
        step("handoff", 4,  0,1,0,0, 0,0,1,0,4);
        step("handoff", 5,  0,1,0,0, 1,1,1,1,3);
        step("handoff", 6,  0,1,0,0, 0,0,1,0,3);
        step("handoff", 7,  0,1,0,0, 0,0,1,0,3);
        // load sampled on a wrap edge applies at the following wrap
        step("handoff", 8,  0,1,1,5, 1,1,1,0,3);
        step("handoff", 9,  0,1,0,0, 0,0,1,0,3);
        step("handoff", 10, 0,1,0,0, 0,0,1,0,3);
        step("handoff", 11, 0,1,0,0, 1,1,1,1,5);
        step("handoff", 12, 0,0,0,0, 1,0,1,0,5);
        for (int k = 0; k < 3; k++) begin
            step("handoff_stop", k, 0,0,0,0, 0,0,1,0,5);
        end
        step("handoff_stop", 3, 0,0,0,0, 0,0,0,0,5);

        // N=6, en drops at cnt=1: period finishes; then STOP->RUN without a break
        step("stop6", 0,  0,0,1,6, 0,0,0,1,6);
        step("stop6", 1,  0,1,0,0, 1,1,1,0,6);
        step("stop6", 2,  0,1,0,0, 1,0,1,0,6);
        step("stop6", 3,  0,0,0,0, 1,0,1,0,6);
        step("stop6", 4,  0,0,0,0, 0,0,1,0,6);
        step("stop6", 5,  0,0,0,0, 0,0,1,0,6);
        step("stop6", 6,  0,0,0,0, 0,0,1,0,6);
        step("stop6", 7,  0,0,0,0, 0,0,0,0,6);
        step("stop6", 8,  0,1,0,0, 1,1,1,0,6);
        step("stop6", 9,  0,1,0,0, 1,0,1,0,6);
        step("stop6", 10, 0,0,0,0, 1,0,1,0,6);
        step("stop6", 11, 0,1,0,0, 0,0,1,0,6);
        step("stop6", 12, 0,1,0,0, 0,0,1,0,6);
        step("stop6", 13, 0,1,0,0, 0,0,1,0,6);
        step("stop6", 14, 0,1,0,0, 1,1,1,0,6);
        step("stop6", 15, 0,1,0,0, 1,0,1,0,6);

        // N=8, reset at cnt=3 with a pending load: pending discarded, back to DEF_RATIO
        step("rst8", 0, 1,0,0,0, 0,0,0,0,2);
        step("rst8", 1, 0,0,1,8, 0,0,0,1,8);
        step("rst8", 2, 0,1,0,0, 1,1,1,0,8);
        step("rst8", 3, 0,1,1,3, 1,0,1,0,8);
        step("rst8", 4, 0,1,0,0, 1,0,1,0,8);
        step("rst8", 5, 0,1,0,0, 1,0,1,0,8);
        step("rst8", 6, 1,1,1,9, 0,0,0,0,2);
        step("rst8", 7, 0,0,0,0, 0,0,0,0,2);
        step("rst8", 8, 0,1,0,0, 1,1,1,0,2);
        step("rst8", 9, 0,1,0,0, 0,0,1,0,2);
        step("rst8", 10, 0,1,0,0, 1,1,1,0,2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
